hack_cpu_ctrl: RTL and testbench
================================

# hack_cpu_ctrl

Multicycle control and register stage of the Hack CPU. It fetches instructions over a valid handshake, holds the A, D, PC and instruction registers, and drives the operands and six control bits of the combinational Hack ALU. It consumes the ALU's out, zr and ng outputs for register writeback, data-memory writes and jump resolution. It sits between the instruction/data memories and the ALU.

## Interface
- No parameters. Data width is fixed at 16 and address width at 15.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc  out  15  instruction address; held stable while instr_req is high
- instr_req  out  1  fetch request
- instr_valid  in  1  instr is valid this cycle; sampled only in FETCH
- instr  in  16  instruction word
- addressM  out  15  data-memory address
- readM / writeM  out  1 each  data read / write request; held until mem_ack
- outM  out  16  write data
- mem_ack  in  1  completes the current readM or writeM
- inM  in  16  read data; valid when mem_ack is high during a read
- alu_x, alu_y  out  16 each  ALU operands
- zx, nx, zy, ny, f, no  out  1 each  ALU control bits
- alu_out  in  16  ALU result
- alu_zr, alu_ng  in  1 each  ALU zero and negative flags

## Operation
- FSM states: FETCH, DECODE, MEM_RD, EXEC, MEM_WR. The reset state is FETCH.
- **FETCH**
  - instr_req=1.
  - On instr_valid: ir<=instr, go to DECODE.
- **DECODE**
  - A-instruction (ir[15]=0): A<=ir, pc<=pc+1, go to FETCH.
  - C-instruction with a-bit ir[12]=1: go to MEM_RD.
  - Otherwise: go to EXEC.
- **MEM_RD**
  - readM=1, addressM=A.
  - On mem_ack: m_reg<=inM, go to EXEC.
- **EXEC**
  - Drive alu_x=D and alu_y=(ir[12] ? m_reg : A).
  - Drive {zx,nx,zy,ny,f,no}=ir[11:6].
  - Destination bits d1/d2/d3 = ir[5]/ir[4]/ir[3] select the A, D and M writes.
  - If d2: D<=alu_out. If d1: A<=alu_out.
  - jump = (ir[2]&ng) | (ir[1]&zr) | (ir[0]&~ng&~zr).
  - pc <= jump ? old A[14:0] : pc+1.
  - If d3: wr_addr<=old A[14:0], wr_data<=alu_out, go to MEM_WR. Otherwise go to FETCH.
- **MEM_WR**
  - writeM=1, addressM=wr_addr, outM=wr_data.
  - On mem_ack: go to FETCH.
- "Old A" means the value of A before this instruction's update. The jump target and M address use it even when d1 is set.
- pc arithmetic is modulo 2^15: pc+1 from 0x7FFF gives 0x0000.
- In C-instructions, ir[14:13] is ignored.
- Outside EXEC, the ALU is still driven from ir and the registers (outputs combinational from the state and registers). Results are captured only in EXEC.

## Timing
- rst_n low, asynchronously and immediately:
  - state=FETCH, pc=0, A=0, D=0, ir=0, m_reg=0, wr_addr=0, wr_data=0.
  - instr_req=1, readM=0, writeM=0.
  - addressM=0, outM=0, alu_x=0, alu_y=0, all ALU control bits 0.
- Reset mid-operation aborts the operation. Any pending readM/writeM drops in the same instant; no register write completes.
- Minimum cycles per instruction, with valid/ack arriving on the first cycle of each wait:
  - A-instruction: 2.
  - C-instruction with no M read/write: 3.
  - M read only: 4. M write only: 4. Read and write: 5.
- Each extra cycle without instr_valid or mem_ack adds one cycle. pc, addressM and outM stay constant during waits.
- instr_valid outside FETCH and mem_ack outside MEM_RD/MEM_WR are ignored.
- readM and writeM are never asserted in the same cycle.

## Structure
- **Package hack_pkg**:
  - state enum.
  - instruction field positions: type bit 15, a-bit 12, comp 11:6, dest 5:3, jump 2:0.
  - constants DATA_W=16 and ADDR_W=15.
- **Sub-module hack_decode** (combinational):
  - Inputs: ir, alu_zr, alu_ng.
  - Outputs: is_c, a_sel, the comp bits, dest_a/dest_d/dest_m, and jump.
- The top module holds the FSM and all registers.

## Test plan
- **Reset**: hold rst_n low mid-MEM_WR -> writeM=0 immediately, pc=0. After release: instr_req=1, pc=0.
- **Load and copy**: 0x0005 then 0xEC10 (D=A) -> A=5, D=5. In EXEC, controls are 110000; pc advances 0->1->2.
- **Memory write**: A=100, D=5, then 0xE7C8 (M=D+1) -> writeM with addressM=100, outM=6. A and D are unchanged.
- **Read-modify-write with A update**: A=100, then 0xFCA8 (AM=M-1); memory returns 6.
  - readM with addressM=100, then writeM with addressM=100 and outM=5.
  - Afterwards A=5.
- **Conditional jump**: A=42, D=0, then 0xE302 (D;JEQ) -> pc=42. Same sequence with D=1 -> pc=old pc+1.
- **Stalls and wrap**:
  - Withhold instr_valid for 4 cycles -> pc and instr_req stable, no state change.
  - Execute an A-instruction at pc=0x7FFF -> pc=0x0000.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU control stage: widths,
// instruction field positions, FSM states and the ALU control bundle.
package hack_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;

  localparam int IR_TYPE    = 15;
  localparam int IR_ABIT    = 12;
  localparam int IR_COMP_HI = 11;
  localparam int IR_COMP_LO = 6;
  localparam int IR_DEST_HI = 5;
  localparam int IR_DEST_LO = 3;
  localparam int IR_JMP_HI  = 2;
  localparam int IR_JMP_LO  = 0;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM_RD = 3'd2,
    EXEC   = 3'd3,
    MEM_WR = 3'd4
  } state_e;

  // Field order matches ir[11:6], so a straight cast of the comp field works.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;
endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Fetch, data-memory and ALU signals of the Hack control stage.
// master = control stage, slave = memories/ALU side.
interface hack_cpu_ctrl_if;
  import hack_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic              instr_req;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;

  logic [ADDR_W-1:0] addressM;
  logic              readM;
  logic              writeM;
  logic [DATA_W-1:0] outM;
  logic              mem_ack;
  logic [DATA_W-1:0] inM;

  logic [DATA_W-1:0] alu_x;
  logic [DATA_W-1:0] alu_y;
  logic              zx, nx, zy, ny, f, no;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zr;
  logic              alu_ng;

  modport master (
    output pc, instr_req, addressM, readM, writeM, outM,
           alu_x, alu_y, zx, nx, zy, ny, f, no,
    input  instr_valid, instr, mem_ack, inM, alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  pc, instr_req, addressM, readM, writeM, outM,
           alu_x, alu_y, zx, nx, zy, ny, f, no,
    output instr_valid, instr, mem_ack, inM, alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_decode.sv
// Combinational instruction decode: type, operand select, ALU controls,
// destinations and jump resolution from the ALU flags.
module hack_decode
  import hack_pkg::*;
(
  input  logic [DATA_W-1:0] ir_i,
  input  logic              alu_zr_i,
  input  logic              alu_ng_i,
  output logic              is_c_o,
  output logic              a_sel_o,
  output alu_ctrl_t         comp_o,
  output logic              dest_a_o,
  output logic              dest_d_o,
  output logic              dest_m_o,
  output logic              jump_o
);
  logic [2:0] dest;
  logic [2:0] jmp;

  assign dest     = ir_i[IR_DEST_HI:IR_DEST_LO];
  assign jmp      = ir_i[IR_JMP_HI:IR_JMP_LO];

  assign is_c_o   = ir_i[IR_TYPE];
  assign a_sel_o  = ir_i[IR_ABIT];
  assign comp_o   = alu_ctrl_t'(ir_i[IR_COMP_HI:IR_COMP_LO]);
  assign dest_a_o = dest[2];
  assign dest_d_o = dest[1];
  assign dest_m_o = dest[0];

  // jmp = {JLT, JEQ, JGT}
  assign jump_o   = (jmp[2] & alu_ng_i) |
                    (jmp[1] & alu_zr_i) |
                    (jmp[0] & ~alu_ng_i & ~alu_zr_i);
endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multicycle Hack CPU control/register stage: fetch handshake, A/D/PC/IR,
// optional M read before EXEC and M write after it.
module hack_cpu_ctrl
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  hack_cpu_ctrl_if.master   bus
);
  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] m_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic      is_c, a_sel, dest_a, dest_d, dest_m, jump;
  alu_ctrl_t comp;

  hack_decode u_dec (
    .ir_i     (ir_q),
    .alu_zr_i (bus.alu_zr),
    .alu_ng_i (bus.alu_ng),
    .is_c_o   (is_c),
    .a_sel_o  (a_sel),
    .comp_o   (comp),
    .dest_a_o (dest_a),
    .dest_d_o (dest_d),
    .dest_m_o (dest_m),
    .jump_o   (jump)
  );

  // Right-hand sides read a_q before any EXEC update, so the jump target and
  // write address use the pre-instruction A even when dest_a is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      a_q       <= '0;
      d_q       <= '0;
      ir_q      <= '0;
      m_q       <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.instr_valid) begin
            ir_q    <= bus.instr;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (!is_c) begin
            a_q     <= ir_q;
            pc_q    <= pc_q + 15'd1;
            state_q <= FETCH;
          end else if (a_sel) begin
            state_q <= MEM_RD;
          end else begin
            state_q <= EXEC;
          end
        end
        MEM_RD: begin
          if (bus.mem_ack) begin
            m_q     <= bus.inM;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (dest_d) d_q <= bus.alu_out;
          if (dest_a) a_q <= bus.alu_out;
          pc_q <= jump ? a_q[ADDR_W-1:0] : pc_q + 15'd1;
          if (dest_m) begin
            wr_addr_q <= a_q[ADDR_W-1:0];
            wr_data_q <= bus.alu_out;
            state_q   <= MEM_WR;
          end else begin
            state_q   <= FETCH;
          end
        end
        MEM_WR: begin
          if (bus.mem_ack) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // Handshake strobes decode straight from state so reset drops them at once.
  assign bus.pc        = pc_q;
  assign bus.instr_req = (state_q == FETCH);
  assign bus.readM     = (state_q == MEM_RD);
  assign bus.writeM    = (state_q == MEM_WR);
  assign bus.addressM  = (state_q == MEM_WR) ? wr_addr_q : a_q[ADDR_W-1:0];
  assign bus.outM      = wr_data_q;

  assign bus.alu_x = d_q;
  assign bus.alu_y = a_sel ? m_q : a_q;
  assign bus.zx    = comp.zx;
  assign bus.nx    = comp.nx;
  assign bus.zy    = comp.zy;
  assign bus.ny    = comp.ny;
  assign bus.f     = comp.f;
  assign bus.no    = comp.no;
endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: Hack ALU model, memory responder with a
// scoreboard of expected memory transactions, linear instruction sequence.
module tb_hack_cpu_ctrl;
  import hack_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hack_cpu_ctrl_if bus ();

  hack_cpu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [15:0] data;
  } mem_exp_t;

  mem_exp_t    sb[$];
  logic [15:0] mem [0:32767];
  int          mem_lat = 0;
  int          wcnt    = 0;

  logic [15:0] ax, ay, ao;
  always_comb begin
    ax = bus.alu_x;
    ay = bus.alu_y;
    if (bus.zx) ax = '0;
    if (bus.nx) ax = ~ax;
    if (bus.zy) ay = '0;
    if (bus.ny) ay = ~ay;
    ao = bus.f ? ax + ay : ax & ay;
    if (bus.no) ao = ~ao;
  end
  assign bus.alu_out = ao;
  assign bus.alu_zr  = (ao == 16'h0000);
  assign bus.alu_ng  = ao[15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    mem_exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_mem_op", {bus.readM, bus.writeM}, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("mem_kind", bus.writeM, e.wr);
      chk("mem_addr", bus.addressM, e.addr);
      if (e.wr) begin
        chk("mem_wdata", bus.outM, e.data);
        mem[bus.addressM] = bus.outM;
      end else begin
        bus.inM = mem[bus.addressM];
      end
    end
  endtask

  // Memory responder: acks after mem_lat waiting cycles, checks against the scoreboard.
  initial begin
    bus.mem_ack = 1'b0;
    bus.inM     = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (!rst_n) begin
        wcnt = 0;
      end else begin
        chk("rw_exclusive", {31'd0, bus.readM & bus.writeM}, 32'd0);
        if (bus.readM || bus.writeM) begin
          if (wcnt >= mem_lat) begin
            wcnt = 0;
            sb_check();
            bus.mem_ack = 1'b1;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  task automatic wait_fetch();
    int n = 0;
    while (!bus.instr_req && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fetch_wait", bus.instr_req, 1);
  endtask

  task automatic fetch(input logic [15:0] w);
    wait_fetch();
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic push_rd(input logic [14:0] a);
    mem_exp_t e;
    e.wr = 1'b0; e.addr = a; e.data = '0;
    sb.push_back(e);
  endtask

  task automatic push_wr(input logic [14:0] a, input logic [15:0] d);
    mem_exp_t e;
    e.wr = 1'b1; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    int n;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    mem[100]        = 16'h0000;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_instr_req", bus.instr_req, 1);
    chk("rst_readM",     bus.readM, 0);
    chk("rst_writeM",    bus.writeM, 0);
    chk("rst_pc",        bus.pc, 0);
    chk("rst_addressM",  bus.addressM, 0);
    chk("rst_outM",      bus.outM, 0);
    chk("rst_alu_x",     bus.alu_x, 0);
    chk("rst_alu_y",     bus.alu_y, 0);
    chk("rst_ctrl",      {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req", bus.instr_req, 1);
    chk("post_rst_pc",  bus.pc, 0);

    // load and copy: @5, D=A
    fetch(16'h0005);
    wait_fetch();
    chk("ainst_pc", bus.pc, 1);
    fetch(16'hEC10);
    @(posedge clk); #1;
    chk("dA_ctrl", {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}, 6'b110000);
    wait_fetch();
    chk("dA_pc", bus.pc, 2);
    chk("dA_D",  bus.alu_x, 5);
    chk("dA_A",  bus.alu_y, 5);

    // memory write: @100, M=D+1
    fetch(16'd100);
    push_wr(15'd100, 16'd6);
    fetch(16'hE7C8);
    wait_fetch();
    chk("mw_pc", bus.pc, 4);
    chk("mw_D",  bus.alu_x, 5);
    chk("mw_A",  bus.alu_y, 100);

    // read-modify-write: @100, AM=M-1 with M=6
    fetch(16'd100);
    push_rd(15'd100);
    push_wr(15'd100, 16'd5);
    fetch(16'hFCA8);
    wait_fetch();
    chk("rmw_pc", bus.pc, 6);
    fetch(16'hEDD0);                 // D=A+1 exposes the new A
    wait_fetch();
    chk("rmw_A", bus.alu_y, 5);
    chk("rmw_D", bus.alu_x, 6);
    chk("rmw_pc2", bus.pc, 7);

    // conditional jump taken: @42, D=0, D;JEQ
    fetch(16'd42);
    fetch(16'hEA90);
    wait_fetch();
    chk("jeq_D0", bus.alu_x, 0);
    fetch(16'hE302);
    wait_fetch();
    chk("jeq_taken_pc", bus.pc, 42);

    // not taken: @42, D=1, D;JEQ
    fetch(16'd42);
    fetch(16'hEFD0);
    wait_fetch();
    chk("jeq_D1", bus.alu_x, 1);
    fetch(16'hE302);
    wait_fetch();
    chk("jeq_nt_pc", bus.pc, 45);

    // fetch stall
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stall_pc",  bus.pc, 45);
      chk("stall_req", bus.instr_req, 1);
    end

    // wrap: jump to 0x7FFF, then an A-instruction
    fetch(16'h7FFF);
    fetch(16'hEA87);
    wait_fetch();
    chk("jmp_pc", bus.pc, 15'h7FFF);
    fetch(16'h0001);
    wait_fetch();
    chk("wrap_pc", bus.pc, 0);

    // reset during a stalled MEM_WR
    mem_lat = 4;
    fetch(16'd100);
    fetch(16'hE7C8);
    n = 0;
    while (!bus.writeM && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_wr_writeM", bus.writeM, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_writeM", bus.writeM, 0);
    chk("rst_mid_pc",     bus.pc, 0);
    chk("rst_mid_req",    bus.instr_req, 1);
    chk("rst_mid_D",      bus.alu_x, 0);
    @(negedge clk) rst_n = 1'b1;
    mem_lat = 0;
    @(posedge clk); #1;
    chk("rel_req", bus.instr_req, 1);
    chk("rel_pc",  bus.pc, 0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
